key_bus_master: RTL

//   Bus initiator for the memory-mapped key responder on the shared ABUS/DBUS/WE bus.
//   - Polls the key control register and reads key data when it is ready.
//   - Clears the responder's overrun flag after an overrun.
//   - Hands each captured key value downstream over a valid/ready handshake.

---
 rtl/key_bus_master.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/key_bus_master.sv
// Bus initiator that polls the memory-mapped key responder and streams captured keys downstream.
// Define KEYMST_INTR_EN to enable the IE bit on KCTRL writes and the INTR wake-up from IDLE.
module key_bus_master #(
   parameter int unsigned      DBITS       = 32,
   parameter logic [DBITS-1:0] BASE        = 32'hFFFFF080,
   parameter int unsigned      KBITS       = 4,
   parameter int unsigned      POLL_CYCLES = 1000
) (
   input  logic             CLK,
   input  logic             RESET_N,
   output logic [DBITS-1:0] ABUS,
   inout  wire  [DBITS-1:0] DBUS,
   output logic             WE,
   input  logic             INTR,
   output logic [KBITS-1:0] KEY_VAL,
   output logic             KEY_VALID,
   input  logic             KEY_READY,
   output logic [7:0]       OVR_CNT,
   output logic             BUSY
);

   localparam int unsigned CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam logic [CW-1:0]    RELOAD     = CW'(POLL_CYCLES - 1);
   localparam logic [DBITS-1:0] KDATA_ADDR = BASE;
   localparam logic [DBITS-1:0] KCTRL_ADDR = BASE + DBITS'(4);
`ifdef KEYMST_INTR_EN
   localparam logic [DBITS-1:0] IEVAL = DBITS'(32'h100);
`else
   localparam logic [DBITS-1:0] IEVAL = '0;
`endif

   typedef enum logic [2:0] {
      StInit, StIdle, StRdCtrl, StRdData, StClrOvr, StPush
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [KBITS-1:0] key_val_q, key_val_d;
   logic [7:0]       ovr_cnt_q, ovr_cnt_d;
   logic             ovr_q, ovr_d;
   logic             have_q, have_d;
   logic             armed_q, armed_d;
   logic [DBITS-1:0] wdata;
   logic             wake;
   logic             unused_sigs;

`ifdef KEYMST_INTR_EN
   assign wake = INTR;
`else
   assign wake = 1'b0;
`endif
   assign unused_sigs = ^{DBUS, INTR};

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q   <= StInit;
         cnt_q     <= RELOAD;
         key_val_q <= '0;
         ovr_cnt_q <= '0;
         ovr_q     <= 1'b0;
         have_q    <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         key_val_q <= key_val_d;
         ovr_cnt_q <= ovr_cnt_d;
         ovr_q     <= ovr_d;
         have_q    <= have_d;
         armed_q   <= armed_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      key_val_d = key_val_q;
      ovr_cnt_d = ovr_cnt_q;
      ovr_d     = ovr_q;
      have_d    = have_q;
      armed_d   = 1'b1;
      ABUS      = '0;
      WE        = 1'b0;
      wdata     = '0;
      KEY_VALID = 1'b0;
      unique case (state_q)
         StInit: begin
            // armed_q keeps the bus quiet while RESET_N is still low.
            if (armed_q) begin
               ABUS    = KCTRL_ADDR;
               WE      = 1'b1;
               wdata   = IEVAL;
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (cnt_q == '0 || wake) begin
               cnt_d   = RELOAD;
               state_d = StRdCtrl;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         StRdCtrl: begin
            ABUS  = KCTRL_ADDR;
            ovr_d = DBUS[2];
            if (DBUS[0])      state_d = StRdData;
            else if (DBUS[2]) state_d = StClrOvr;
            else              state_d = StIdle;
         end
         StRdData: begin
            ABUS      = KDATA_ADDR;
            key_val_d = DBUS[KBITS-1:0];
            have_d    = 1'b1;
            state_d   = ovr_q ? StClrOvr : StPush;
         end
         StClrOvr: begin
            ABUS  = KCTRL_ADDR;
            WE    = 1'b1;
            wdata = IEVAL;
            if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
            state_d = have_q ? StPush : StIdle;
         end
         StPush: begin
            KEY_VALID = 1'b1;
            if (KEY_READY) begin
               have_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StInit;
      endcase
   end

   assign DBUS    = WE ? wdata : 'z;
   assign KEY_VAL = key_val_q;
   assign OVR_CNT = ovr_cnt_q;
   assign BUSY    = (state_q != StIdle);

endmodule
